stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised multi-cycle stage controller. It walks a single instruction through N_STAGES sequential stages and produces one-hot stage-active and stage-fire enables for the pipeline registers, PC, RAM and register file.
- It generalises the fixed 10-state sequencer by adding the following:
  - per-stage stall inputs
  - flush/restart
  - graceful halt
  - single-step mode
  - a retired-instruction counter
- It sits at core top level and drives every *_wren in the datapath.

Parameters:
- N_STAGES, 10, number of stages in one instruction loop (index 0 = IF, N_STAGES-1 = last stage, e.g. WB_IF); legal range 2..32.
- STAGE_W, $clog2(N_STAGES), width of the stage index.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  level; 1 = run instructions, 0 = halt at the next instruction boundary.
- stall_req  in  N_STAGES  bit k = hold stage k this cycle (e.g. memory busy).
- flush  in  1  pulse; abort the current instruction and restart at stage 0.
- step_mode  in  1  1 = stop after every instruction and wait for step.
- step  in  1  pulse; release one instruction while paused.
- stage  out  STAGE_W  current stage index (registered).
- stage_active  out  N_STAGES  one-hot of stage while in RUN, else 0 (registered).
- stage_fire  out  N_STAGES  stage_active & ~stall_req (combinational); these are the write enables.
- stage_reset_n  out  1  0 in INIT, 1 otherwise (registered).
- busy  out  1  1 in RUN.
- commit  out  1  1-cycle pulse when the last stage fires.
- instr_count  out  CNT_W  number of committed instructions.

Behaviour:

Reset:
- While reset_n=0 at posedge: state=INIT, stage=0, stage_active=0, stage_reset_n=0, busy=0, instr_count=0.
- commit=0 and stage_fire=0 follow from these values.
- Reset mid-instruction aborts it immediately; no commit.

Top FSM (states INIT, RUN, HALT, PAUSE):
- INIT: exactly 1 cycle after reset release, stage_reset_n=0. Next state is RUN if enable=1, else HALT. On exit, stage_reset_n goes to 1 and is never re-asserted until the next reset.
- RUN:
  - If stall_req[stage]=1, hold stage; stage_fire=0.
  - Else advance: stage <= stage+1.
  - At stage N_STAGES-1 the fire is an instruction boundary: commit=1 for that cycle, instr_count+1, stage <= 0.
  - At the boundary, next state is:
    - HALT if enable=0;
    - else PAUSE if step_mode=1;
    - else RUN.
- HALT: stage_active=0, busy=0. On enable=1 go to RUN at stage 0 on the next cycle.
- PAUSE: stage_active=0, busy=0. On a step pulse (with enable=1) go to RUN at stage 0. If step_mode drops while paused and enable=1, go to RUN. If enable=0, go to HALT.

Timing:
- With no stalls, one instruction takes exactly N_STAGES cycles.
- Back-to-back instructions have no bubble: stage N_STAGES-1 is followed directly by stage 0.

Flush:
- In RUN, flush=1 forces stage <= 0 next cycle, regardless of stall.
- No commit and no counter increment, even if the flush cycle is at the last stage; stage_fire is still computed normally in that cycle.
- In HALT, PAUSE or INIT, flush is ignored.

Precedence:
- Within a RUN cycle: reset > flush > stall > advance.
- enable and step_mode are sampled only at instruction boundaries (and in HALT/PAUSE).

Counter:
- instr_count wraps modulo 2^CNT_W with no saturation.

Invariants:
- stage_active is one-hot or zero.
- stage < N_STAGES always.
- stall_req bits for non-current stages have no effect.

Decomposition:
- Shared package stage_pkg:
  - typedef enum seq_state_t {INIT, RUN, HALT, PAUSE};
  - localparams naming the default 10-stage map (STG_IF=0, STG_IF_ID=1 … STG_WB_IF=9) so datapath code indexes stage_fire by name.
- One natural sub-module: stage_counter (wrapping mod-N index with hold/clear/advance and a terminal-count output), reused for the loop index.
- The instruction counter is inline.

Test Plan:
1. Free-run: reset 2 cycles, enable=1, no stalls, N_STAGES=10. Required response:
   - stage_reset_n=0 for exactly 1 cycle;
   - stage sequences 0..9 repeatedly;
   - commit every 10th cycle;
   - instr_count=3 after 30 RUN cycles.
2. Stall: hold stall_req[6]=1 for 4 cycles while stage=6. Required response:
   - stage stays 6 for 5 cycles;
   - stage_fire[6] asserts only in the final cycle;
   - that instruction takes 14 cycles.
3. Flush: pulse flush at stage 9 while stall_req=0. Required response:
   - next stage=0;
   - no commit;
   - instr_count unchanged.
   Repeat with stall_req[4]=1 and flush at stage 4: next stage=0.
4. Graceful halt: drop enable at stage 3. Required response:
   - stages 4..9 still complete and commit fires;
   - then busy=0 and stage_active=0;
   - re-raise enable: stage=0 next cycle.
5. Single-step: step_mode=1. Required response:
   - exactly one instruction runs, then PAUSE;
   - each step pulse yields exactly one commit;
   - 3 steps give instr_count=3.
6. Parameter/wrap: N_STAGES=2, CNT_W=4, 17 instructions. Required response:
   - stage toggles 0/1;
   - instr_count wraps to 1;
   - reset asserted mid-instruction returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared types and stage-index names for the instruction stage sequencer.
// Datapath code indexes stage_fire with the STG_* names of the default 10-stage loop.
// Carries no logic of its own.
package stage_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        PAUSE = 2'd3
    } seq_state_t;

    localparam int DEFAULT_N_STAGES = 10;

    localparam int STG_IF     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID     = 2;
    localparam int STG_ID_EX  = 3;
    localparam int STG_EX     = 4;
    localparam int STG_EX_MEM = 5;
    localparam int STG_MEM    = 6;
    localparam int STG_MEM_WB = 7;
    localparam int STG_WB     = 8;
    localparam int STG_WB_IF  = 9;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and the core datapath.
// master = sequencer side (drives enables); slave = core/debug side (drives run controls).
// Purely a wiring bundle; no timing of its own.
interface stage_sequencer_if #(
    parameter int N_STAGES = 10,
    parameter int STAGE_W  = $clog2(N_STAGES),
    parameter int CNT_W    = 32
);
    logic                enable;
    logic [N_STAGES-1:0] stall_req;
    logic                flush;
    logic                step_mode;
    logic                step;

    logic [STAGE_W-1:0]  stage;
    logic [N_STAGES-1:0] stage_active;
    logic [N_STAGES-1:0] stage_fire;
    logic                stage_reset_n;
    logic                busy;
    logic                commit;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  enable, stall_req, flush, step_mode, step,
        output stage, stage_active, stage_fire, stage_reset_n, busy, commit, instr_count
    );

    modport slave (
        output enable, stall_req, flush, step_mode, step,
        input  stage, stage_active, stage_fire, stage_reset_n, busy, commit, instr_count
    );
endinterface

// File: rtl/stage_counter.sv
// Wrapping mod-N index with clear > advance > hold priority and a terminal-count flag.
// Index is registered; tc is combinational from the index.
// No backpressure: the owner decides each cycle whether to advance.
module stage_counter #(
    parameter int N = 10,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] idx,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (idx == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= tc ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/stage_sequencer.sv
// Walks one instruction at a time through N_STAGES stages, emitting one-hot active/fire enables.
// Stage index and state registered; stage_fire and commit are same-cycle combinational.
// A stall on the current stage holds it; enable/step_mode act only at instruction boundaries.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int N_STAGES = 10,
    parameter int STAGE_W  = $clog2(N_STAGES),
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    stage_sequencer_if.master   seq
);
    seq_state_t          state_q;
    seq_state_t          state_d;
    logic                srn_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [STAGE_W-1:0]  stage_idx;
    logic                last_stage;
    logic                run;
    logic                cur_stall;
    logic                ctr_clear;
    logic                ctr_adv;
    logic                commit_c;
    logic [N_STAGES-1:0] stage_oh;
    logic [N_STAGES-1:0] active;

    stage_counter #(
        .N (N_STAGES),
        .W (STAGE_W)
    ) u_loop_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ctr_clear),
        .advance (ctr_adv),
        .idx     (stage_idx),
        .tc      (last_stage)
    );

    assign run      = (state_q == RUN);
    assign stage_oh = {{(N_STAGES-1){1'b0}}, 1'b1} << stage_idx;
    assign active   = run ? stage_oh : '0;

    // Masking with the active one-hot makes stall bits of other stages irrelevant.
    assign cur_stall = |(active & seq.stall_req);
    // Flush at the last stage still fires its enables but is not an instruction boundary.
    assign commit_c  = run && last_stage && !cur_stall && !seq.flush;

    always_comb begin
        state_d   = state_q;
        ctr_clear = 1'b0;
        ctr_adv   = 1'b0;
        unique case (state_q)
            INIT: begin
                ctr_clear = 1'b1;
                state_d   = seq.enable ? RUN : HALT;
            end
            RUN: begin
                if (seq.flush) begin
                    ctr_clear = 1'b1;
                end else if (!cur_stall) begin
                    ctr_adv = 1'b1;
                    if (last_stage) begin
                        if (!seq.enable) begin
                            state_d = HALT;
                        end else if (seq.step_mode) begin
                            state_d = PAUSE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            HALT: begin
                ctr_clear = 1'b1;
                if (seq.enable) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                ctr_clear = 1'b1;
                if (!seq.enable) begin
                    state_d = HALT;
                end else if (seq.step || !seq.step_mode) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            srn_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Datapath reset is released once, on leaving INIT, and stays released.
            if (state_q == INIT) begin
                srn_q <= 1'b1;
            end
            if (commit_c) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign seq.stage         = stage_idx;
    assign seq.stage_active  = active;
    assign seq.stage_fire    = active & ~seq.stall_req;
    assign seq.stage_reset_n = srn_q;
    assign seq.busy          = run;
    assign seq.commit        = commit_c;
    assign seq.instr_count   = cnt_q;

    a_active_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(seq.stage_active));
    a_stage_in_range : assert property (@(posedge clk) disable iff (!reset_n)
        32'(seq.stage) < N_STAGES);
    a_fire_within_active : assert property (@(posedge clk) disable iff (!reset_n)
        (seq.stage_fire & ~seq.stage_active) == '0);
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: 10-stage instance for run/stall/flush/halt/step, 2-stage instance for wrap.
// Commits are checked against a queue of expected commit cycles.
module tb_stage_sequencer;
    import stage_pkg::*;

    localparam int NA  = 10;
    localparam int NB  = 2;
    localparam int CWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    stage_sequencer_if #(.N_STAGES(NA)) ifa ();
    stage_sequencer_if #(.N_STAGES(NB), .CNT_W(CWB)) ifb ();

    stage_sequencer #(.N_STAGES(NA)) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .seq     (ifa)
    );

    stage_sequencer #(.N_STAGES(NB), .CNT_W(CWB)) dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .seq     (ifb)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int exp_cnt = 0;
    int exp_q[$];

    typedef struct {
        int ss;
        int sl;
        bit noise;
        int exp_len;
        int exp_hold;
    } vec_t;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every commit of instance A must match the next expected commit cycle.
    always @(negedge clk) begin
        if (rst_a_n === 1'b1 && ifa.commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit_unexpected: got commit at cycle %0d want none", cyc_n);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("commit_cycle", cyc_n, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_commit(input int dly);
        exp_q.push_back(cyc_n + dly);
        exp_cnt++;
    endtask

    task automatic run_to(input int t);
        for (int c = 0; c < 20 && int'(ifa.stage) != t; c++) nxt();
        chk("run_to_stage", ifa.stage, t);
    endtask

    task automatic run_instr(input vec_t v, input string nm);
        int len  = 0;
        int hold = 0;
        int rem  = v.sl;
        bit done = 0;
        chk({nm, "_start_stage"}, ifa.stage, 0);
        push_commit(v.exp_len - 1);
        for (int c = 0; c < 64 && !done; c++) begin
            int s;
            logic [NA-1:0] oh;
            bit stl;
            s   = int'(ifa.stage);
            oh  = NA'(1) << s;
            stl = (s == v.ss) && (rem > 0);
            ifa.stall_req = (stl ? oh : '0) | (v.noise ? ~oh : '0);
            #1;
            chk({nm, "_fire"}, ifa.stage_fire, stl ? '0 : oh);
            if (s == v.ss) hold++;
            if (stl) rem--;
            len++;
            if (ifa.commit === 1'b1) done = 1;
            nxt();
        end
        ifa.stall_req = '0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no commit within 64 cycles want commit", nm);
        end
        chk({nm, "_len"}, len, v.exp_len);
        chk({nm, "_hold"}, hold, v.exp_hold);
        chk({nm, "_count"}, ifa.instr_count, exp_cnt);
    endtask

    vec_t tbl[6];

    initial begin
        tbl = '{
            '{6, 4, 1'b0, 14, 5},
            '{0, 2, 1'b0, 12, 3},
            '{9, 1, 1'b0, 11, 2},
            '{3, 0, 1'b0, 10, 1},
            '{5, 3, 1'b1, 13, 4},
            '{2, 0, 1'b1, 10, 1}
        };

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.enable = 1'b1; ifa.stall_req = '0; ifa.flush = 1'b0; ifa.step_mode = 1'b0; ifa.step = 1'b0;
        ifb.enable = 1'b0; ifb.stall_req = '0; ifb.flush = 1'b0; ifb.step_mode = 1'b0; ifb.step = 1'b0;

        // Reset and free-run
        nxt(); nxt();
        chk("rst_stage", ifa.stage, 0);
        chk("rst_active", ifa.stage_active, 0);
        chk("rst_fire", ifa.stage_fire, 0);
        chk("rst_srn", ifa.stage_reset_n, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_commit", ifa.commit, 0);
        chk("rst_count", ifa.instr_count, 0);
        rst_a_n = 1'b1;
        #1;
        chk("init_srn", ifa.stage_reset_n, 0);
        chk("init_busy", ifa.busy, 0);
        nxt();
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) push_commit(9);
            #1;
            chk("free_stage", ifa.stage, i % 10);
            chk("free_srn", ifa.stage_reset_n, 1);
            chk("free_busy", ifa.busy, 1);
            chk("free_fire", ifa.stage_fire, NA'(1) << (i % 10));
            chk("free_commit", ifa.commit, (i % 10 == 9) ? 1 : 0);
            nxt();
        end
        chk("free_count3", ifa.instr_count, 3);

        // Stall table
        foreach (tbl[k]) run_instr(tbl[k], $sformatf("stall%0d", k));

        // Flush at last stage, then flush overriding a stall
        run_to(9);
        ifa.flush = 1'b1;
        #1;
        chk("flush9_commit", ifa.commit, 0);
        chk("flush9_fire", ifa.stage_fire, NA'(1) << 9);
        nxt();
        ifa.flush = 1'b0;
        chk("flush9_next_stage", ifa.stage, 0);
        chk("flush9_count", ifa.instr_count, exp_cnt);
        run_to(4);
        ifa.stall_req = NA'(1) << 4;
        ifa.flush = 1'b1;
        #1;
        chk("flush4_fire", ifa.stage_fire, 0);
        nxt();
        ifa.flush = 1'b0;
        ifa.stall_req = '0;
        chk("flush4_next_stage", ifa.stage, 0);

        // Graceful halt
        run_to(3);
        ifa.enable = 1'b0;
        push_commit(6);
        for (int k = 3; k <= 9; k++) begin
            #1;
            chk("halt_drain_stage", ifa.stage, k);
            nxt();
        end
        chk("halt_busy", ifa.busy, 0);
        chk("halt_active", ifa.stage_active, 0);
        chk("halt_count", ifa.instr_count, exp_cnt);
        ifa.flush = 1'b1;
        #1;
        chk("halt_flush_fire", ifa.stage_fire, 0);
        nxt();
        ifa.flush = 1'b0;
        nxt();
        chk("halt_hold_busy", ifa.busy, 0);
        ifa.enable = 1'b1;
        nxt();
        chk("resume_stage", ifa.stage, 0);
        chk("resume_busy", ifa.busy, 1);
        chk("resume_active", ifa.stage_active, 1);

        // Single-step
        ifa.step_mode = 1'b1;
        push_commit(9);
        for (int k = 0; k < 10; k++) nxt();
        for (int k = 0; k < 3; k++) begin
            chk("pause_busy", ifa.busy, 0);
            nxt();
        end
        begin
            int base;
            base = exp_cnt;
            for (int s = 0; s < 3; s++) begin
                ifa.step = 1'b1;
                #1;
                chk("step_wait_busy", ifa.busy, 0);
                nxt();
                ifa.step = 1'b0;
                push_commit(9);
                for (int k = 0; k < 10; k++) begin
                    #1;
                    chk("step_stage", ifa.stage, k);
                    chk("step_run_busy", ifa.busy, 1);
                    nxt();
                end
                chk("step_paused", ifa.busy, 0);
                nxt();
                chk("step_still_paused", ifa.busy, 0);
            end
            chk("step_count", ifa.instr_count, base + 3);
        end
        ifa.step_mode = 1'b0;
        nxt();
        chk("unpause_busy", ifa.busy, 1);
        chk("unpause_stage", ifa.stage, 0);
        ifa.enable = 1'b0;
        push_commit(9);
        for (int k = 0; k < 10; k++) nxt();
        chk("final_busy", ifa.busy, 0);
        nxt();
        chk("scoreboard_empty", exp_q.size(), 0);

        // Two-stage instance: toggle, counter wrap, mid-instruction reset
        ifb.enable = 1'b1;
        nxt(); nxt();
        chk("b_rst_srn", ifb.stage_reset_n, 0);
        chk("b_rst_count", ifb.instr_count, 0);
        rst_b_n = 1'b1;
        nxt();
        for (int i = 0; i < 34; i++) begin
            #1;
            chk("b_stage", ifb.stage, i % 2);
            chk("b_commit", ifb.commit, i % 2);
            nxt();
        end
        chk("b_wrap_count", ifb.instr_count, 1);
        nxt();
        chk("b_mid_stage", ifb.stage, 1);
        rst_b_n = 1'b0;
        nxt();
        chk("b_mrst_stage", ifb.stage, 0);
        chk("b_mrst_active", ifb.stage_active, 0);
        chk("b_mrst_fire", ifb.stage_fire, 0);
        chk("b_mrst_srn", ifb.stage_reset_n, 0);
        chk("b_mrst_busy", ifb.busy, 0);
        chk("b_mrst_commit", ifb.commit, 0);
        chk("b_mrst_count", ifb.instr_count, 0);
        rst_b_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
